morty_lsu: RTL and testbench

- Load/store unit directly upstream of the MEM stage's data return path.
- Consumes the MEM-stage access flags, effective address and store data, and runs one Wishbone classic data-bus cycle per access.
- Returns aligned, sign- or zero-extended load data and a bus error flag (mem_data_i / mem_err_i of the MEM stage).
- Stalls the pipeline until the access completes.

---
 rtl/morty_lsu.sv | 189 ++++++++++++++++++
 tb/tb_morty_lsu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/morty_lsu.sv
// rtl/morty_lsu.sv - load/store unit driving one Wishbone classic data-bus cycle per MEM-stage access
//
// Purpose: issues one Wishbone classic cycle per legal MEM-stage load/store and
// returns an aligned, extended load result plus an error flag. It holds the
// pipeline until the access completes.
//
// Ports:
//   clk_i, rst_i             clock (rising edge), async active-low reset
//   lsu_addr_i/wdata_i       effective address, store data
//   lsu_flags_i              [5]write [4]read [3]word [2]half [1]byte [0]unsigned
//   lsu_kill_i               suppresses issue while a trap is pending
//   lsu_pipe_stall_i         downstream stall; keeps the unit in DONE
//   lsu_data_o/err_o         completed access result and bus/timeout error
//   lsu_stall_o              combinational stall request to the pipeline
//   dwbm_*                   Wishbone classic master port
module morty_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [5:0]  lsu_flags_i,
  input  logic        lsu_kill_i,
  input  logic        lsu_pipe_stall_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_err_o,
  output logic        lsu_stall_o,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_we_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // The counter value seen on the last BUSY cycle allowed before timing out.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, dat_q, data_q;
  logic [3:0]  sel_q;
  logic        we_q, cyc_q, err_q;
  logic [7:0]  cnt_q;
  logic [1:0]  off_q;
  logic        word_q, half_q, uns_q;

  logic        f_write, f_read, f_word, f_half, f_byte, f_uns;
  logic        misaligned, req, timeout;
  logic [3:0]  sel_c;
  logic [31:0] wdat_c;
  logic [15:0] lane_h;
  logic [7:0]  lane_b;
  logic [31:0] rd_ext;

  assign f_write = lsu_flags_i[5];
  assign f_read  = lsu_flags_i[4];
  assign f_word  = lsu_flags_i[3];
  assign f_half  = lsu_flags_i[2];
  assign f_byte  = lsu_flags_i[1];
  assign f_uns   = lsu_flags_i[0];

  assign misaligned = (f_word & (lsu_addr_i[1:0] != 2'b00)) | (f_half & lsu_addr_i[0]);
  assign req        = (f_read | f_write) & ~lsu_kill_i & ~misaligned;
  assign timeout    = (cnt_q == TMO_LAST);

  // Lane select and store replication; size flags resolve word > half > byte.
  always_comb begin
    sel_c  = 4'b0000;
    wdat_c = {4{lsu_wdata_i[7:0]}};
    if (f_word) begin
      sel_c  = 4'b1111;
      wdat_c = lsu_wdata_i;
    end else if (f_half) begin
      sel_c  = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
      wdat_c = {2{lsu_wdata_i[15:0]}};
    end else if (f_byte) begin
      sel_c  = 4'b0001 << lsu_addr_i[1:0];
    end
  end

  // Load extraction uses the size/offset captured at issue, not the live flags.
  always_comb begin
    lane_h = off_q[1] ? dwbm_dat_i[31:16] : dwbm_dat_i[15:0];
    case (off_q)
      2'd0:    lane_b = dwbm_dat_i[7:0];
      2'd1:    lane_b = dwbm_dat_i[15:8];
      2'd2:    lane_b = dwbm_dat_i[23:16];
      default: lane_b = dwbm_dat_i[31:24];
    endcase
    if (word_q)
      rd_ext = dwbm_dat_i;
    else if (half_q)
      rd_ext = uns_q ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
    else
      rd_ext = uns_q ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    lsu_stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        lsu_stall_o = req;
        if (req) state_d = BUSY;
      end
      BUSY: begin
        lsu_stall_o = 1'b1;
        if (dwbm_ack_i || dwbm_err_i || timeout) state_d = DONE;
      end
      DONE: begin
        // Leaving DONE always lands in IDLE, so back-to-back accesses get a gap cycle.
        if (!lsu_pipe_stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q <= '0;
      dat_q  <= '0;
      sel_q  <= '0;
      we_q   <= 1'b0;
      cyc_q  <= 1'b0;
      cnt_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      off_q  <= '0;
      word_q <= 1'b0;
      half_q <= 1'b0;
      uns_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q <= {lsu_addr_i[31:2], 2'b00};
            dat_q  <= wdat_c;
            sel_q  <= sel_c;
            we_q   <= f_write;
            cyc_q  <= 1'b1;
            cnt_q  <= '0;
            off_q  <= lsu_addr_i[1:0];
            word_q <= f_word;
            half_q <= f_half;
            uns_q  <= f_uns;
          end
        end
        BUSY: begin
          if (dwbm_ack_i || dwbm_err_i) begin
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            // ack wins over a simultaneous err; an errored load returns 0.
            data_q <= (dwbm_ack_i && !we_q) ? rd_ext : 32'h0;
            err_q  <= dwbm_err_i & ~dwbm_ack_i;
          end else if (timeout) begin
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            data_q <= 32'h0;
            err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dwbm_addr_o = addr_q;
  assign dwbm_dat_o  = dat_q;
  assign dwbm_sel_o  = sel_q;
  assign dwbm_we_o   = we_q;
  assign dwbm_cyc_o  = cyc_q;
  assign dwbm_stb_o  = cyc_q;
  assign lsu_data_o  = data_q;
  assign lsu_err_o   = err_q;

endmodule

// File: tb/tb_morty_lsu.sv
// tb/tb_morty_lsu.sv - directed-vector bench for morty_lsu
module tb_morty_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] lsu_addr_i = '0;
  logic [31:0] lsu_wdata_i = '0;
  logic [5:0]  lsu_flags_i = '0;
  logic        lsu_kill_i = 1'b0;
  logic        lsu_pipe_stall_i = 1'b0;
  logic [31:0] lsu_data_o;
  logic        lsu_err_o;
  logic        lsu_stall_o;
  logic [31:0] dwbm_addr_o;
  logic [31:0] dwbm_dat_o;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_we_o;
  logic        dwbm_cyc_o;
  logic        dwbm_stb_o;
  logic [31:0] dwbm_dat_i = '0;
  logic        dwbm_ack_i = 1'b0;
  logic        dwbm_err_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  localparam int RESP_ACK = 0;
  localparam int RESP_ERR = 1;
  localparam int RESP_NONE = 2;

  morty_lsu #(.TIMEOUT_CYCLES(255)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_flags_i(lsu_flags_i),
    .lsu_kill_i(lsu_kill_i), .lsu_pipe_stall_i(lsu_pipe_stall_i),
    .lsu_data_o(lsu_data_o), .lsu_err_o(lsu_err_o), .lsu_stall_o(lsu_stall_o),
    .dwbm_addr_o(dwbm_addr_o), .dwbm_dat_o(dwbm_dat_o), .dwbm_sel_o(dwbm_sel_o),
    .dwbm_we_o(dwbm_we_o), .dwbm_cyc_o(dwbm_cyc_o), .dwbm_stb_o(dwbm_stb_o),
    .dwbm_dat_i(dwbm_dat_i), .dwbm_ack_i(dwbm_ack_i), .dwbm_err_i(dwbm_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  // Presents one access, plays the slave (waits, then ack/err/nothing), and
  // checks bus fields on the first BUSY cycle plus the completed result.
  task automatic run_access(
    input string       name,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [5:0]  flags,
    input int          waits,
    input int          resp,
    input logic [31:0] rdata,
    input int          hold,
    input logic [31:0] exp_addr,
    input logic [3:0]  exp_sel,
    input logic [31:0] exp_dat,
    input logic        exp_we,
    input logic [31:0] exp_data,
    input logic        exp_err,
    input int          exp_stall
  );
    int n_stall = 0;
    int n_busy = 0;
    logic finished = 1'b0;
    logic [31:0] c_addr = '0, c_dat = '0;
    logic [3:0]  c_sel = '0;
    logic        c_we = 1'b0, c_stb = 1'b0;
    @(negedge clk_i);
    lsu_addr_i  = addr;
    lsu_wdata_i = wdata;
    lsu_flags_i = flags;
    lsu_kill_i  = 1'b0;
    for (int k = 0; k < 600 && !finished; k++) begin
      #1;
      if (!lsu_stall_o) begin
        finished = 1'b1;
      end else begin
        n_stall++;
        if (dwbm_cyc_o) begin
          if (n_busy == 0) begin
            c_addr = dwbm_addr_o; c_dat = dwbm_dat_o; c_sel = dwbm_sel_o;
            c_we = dwbm_we_o; c_stb = dwbm_stb_o;
          end
          if (n_busy == waits && resp != RESP_NONE) begin
            dwbm_dat_i = rdata;
            dwbm_ack_i = (resp == RESP_ACK);
            dwbm_err_i = (resp == RESP_ERR);
          end
          n_busy++;
        end
        @(negedge clk_i);
        dwbm_ack_i = 1'b0;
        dwbm_err_i = 1'b0;
      end
    end
    check_vec({name, ".completed"}, 32'(finished), 32'd1);
    check_vec({name, ".addr"}, c_addr, exp_addr);
    check_vec({name, ".sel"}, 32'(c_sel), 32'(exp_sel));
    check_vec({name, ".we"}, 32'(c_we), 32'(exp_we));
    check_vec({name, ".stb"}, 32'(c_stb), 32'd1);
    if (exp_we) check_vec({name, ".dat_o"}, c_dat, exp_dat);
    check_vec({name, ".stall_cycles"}, 32'(n_stall), 32'(exp_stall));
    check_vec({name, ".cyc_done"}, 32'(dwbm_cyc_o), 32'd0);
    check_vec({name, ".data"}, lsu_data_o, exp_data);
    check_vec({name, ".err"}, 32'(lsu_err_o), 32'(exp_err));
    // Instruction stays presented while downstream holds it in DONE.
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i); #1;
      check_vec({name, ".hold_cyc"}, 32'(dwbm_cyc_o), 32'd0);
      check_vec({name, ".hold_stall"}, 32'(lsu_stall_o), 32'd0);
      check_vec({name, ".hold_data"}, lsu_data_o, exp_data);
    end
    lsu_flags_i = 6'b000000;
    lsu_pipe_stall_i = 1'b0;
    @(negedge clk_i); #1;
    check_vec({name, ".idle_data"}, lsu_data_o, exp_data);
    check_vec({name, ".idle_cyc"}, 32'(dwbm_cyc_o), 32'd0);
  endtask

  // Presents an access that must never reach the bus.
  task automatic run_blocked(input string name, input logic [31:0] addr,
                             input logic [5:0] flags, input logic kill);
    @(negedge clk_i);
    lsu_addr_i  = addr;
    lsu_flags_i = flags;
    lsu_kill_i  = kill;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_vec({name, ".stall"}, 32'(lsu_stall_o), 32'd0);
      check_vec({name, ".cyc"}, 32'(dwbm_cyc_o), 32'd0);
      @(negedge clk_i);
    end
    lsu_flags_i = 6'b000000;
    lsu_kill_i  = 1'b0;
  endtask

  initial begin
    #12;
    check_vec("reset.cyc", 32'(dwbm_cyc_o), 32'd0);
    check_vec("reset.stb", 32'(dwbm_stb_o), 32'd0);
    check_vec("reset.addr", dwbm_addr_o, 32'h0);
    check_vec("reset.data", lsu_data_o, 32'h0);
    check_vec("reset.err", 32'(lsu_err_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    run_access("lb_signed", 32'h0000_1003, 32'h0, 6'b010010, 0, RESP_ACK, 32'h80FF_FF00, 0,
               32'h0000_1000, 4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b0, 2);

    run_access("lhu", 32'h0000_2002, 32'h0, 6'b010101, 0, RESP_ACK, 32'h8001_1234, 0,
               32'h0000_2000, 4'b1100, 32'h0, 1'b0, 32'h0000_8001, 1'b0, 2);

    run_access("sb_wait3", 32'h0000_3001, 32'h0000_00AB, 6'b100010, 3, RESP_ACK, 32'h0, 0,
               32'h0000_3000, 4'b0010, 32'hABAB_ABAB, 1'b1, 32'h0, 1'b0, 5);

    // A load first so lsu_data_o is non-zero before the reset.
    run_access("lw", 32'h0000_6004, 32'h0, 6'b011000, 1, RESP_ACK, 32'hCAFE_F00D, 0,
               32'h0000_6004, 4'b1111, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0, 3);

    // Reset mid-BUSY: cyc/stb must drop between clock edges.
    @(negedge clk_i);
    lsu_addr_i  = 32'h0000_7000;
    lsu_flags_i = 6'b011000;
    @(negedge clk_i); #1;
    check_vec("rst_busy.cyc_before", 32'(dwbm_cyc_o), 32'd1);
    lsu_flags_i = 6'b000000;
    #1;
    rst_i = 1'b0;
    #1;
    check_vec("rst_busy.cyc_async", 32'(dwbm_cyc_o), 32'd0);
    check_vec("rst_busy.stb_async", 32'(dwbm_stb_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i); #1;
    check_vec("rst_busy.data", lsu_data_o, 32'h0);
    check_vec("rst_busy.stall", 32'(lsu_stall_o), 32'd0);
    check_vec("rst_busy.cyc_after", 32'(dwbm_cyc_o), 32'd0);

    run_blocked("misaligned_lw", 32'h0000_4002, 6'b011000, 1'b0);
    run_blocked("killed_lw", 32'h0000_4000, 6'b011000, 1'b1);

    run_access("err_first", 32'h0000_5000, 32'h0, 6'b011000, 0, RESP_ERR, 32'h1234_5678, 0,
               32'h0000_5000, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b1, 2);

    run_access("timeout", 32'h0000_8000, 32'h0, 6'b011000, 0, RESP_NONE, 32'h0, 0,
               32'h0000_8000, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b1, 256);

    // Downstream stall holds DONE for 4 cycles with the load still presented.
    lsu_pipe_stall_i = 1'b1;
    run_access("pipe_hold", 32'h0000_9001, 32'h0, 6'b010011, 0, RESP_ACK, 32'h0000_F700, 4,
               32'h0000_9000, 4'b0010, 32'h0, 1'b0, 32'h0000_00F7, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
